// File: rtl/tdc_pkg.sv
// Shared constants and FSM encoding for the TDC column readout path.
package tdc_pkg;

  localparam int BITS_UNSIG_TDC = 15;
  localparam int NUM_COL        = 16;
  localparam int CNT_COL        = 4;

  // 4-bit encoding, same width as the command FSM so debug buses line up.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_WAIT  = 4'd2,
    ST_SHIFT = 4'd3,
    ST_DONE  = 4'd4
  } tdc_state_e;

endpackage

// File: rtl/tdc_word_fifo.sv
// Two-entry {col, data} FIFO. The head entry is a register that drives the
// outputs directly; a second register holds the word behind it.
// Handshake: a word leaves when valid && ready at a rising edge; a push that
// finds the FIFO full without a pop in the same cycle is dropped and flagged.
module tdc_word_fifo #(
  parameter int W_DATA = tdc_pkg::BITS_UNSIG_TDC,
  parameter int W_COL  = tdc_pkg::CNT_COL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W_COL-1:0]  push_col,
  input  logic [W_DATA-1:0] push_data,
  input  logic              pop_ready,
  output logic [W_DATA-1:0] head_data,
  output logic [W_COL-1:0]  head_col,
  output logic              head_valid,
  output logic              drop
);

  logic [W_DATA-1:0] tail_data;
  logic [W_COL-1:0]  tail_col;
  logic [1:0]        count;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push_ok;

  assign empty      = (count == 2'd0);
  assign full       = (count == 2'd2);
  assign head_valid = !empty;
  assign pop        = head_valid && pop_ready;
  // A pop frees the slot in the same cycle, so push+pop on full is accepted.
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;

  // Storage update: advance tail into head on pop, then place the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      head_data <= '0;
      head_col  <= '0;
      tail_data <= '0;
      tail_col  <= '0;
    end else begin
      if (pop && full) begin
        head_data <= tail_data;
        head_col  <= tail_col;
      end
      if (push_ok) begin
        if (empty || (count == 2'd1 && pop)) begin
          head_data <= push_data;
          head_col  <= push_col;
        end else begin
          tail_data <= push_data;
          tail_col  <= push_col;
        end
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/tdc_chain_readout.sv
// Chain-end controller: pulses flag_col to load every column, then
// deserializes the MSB-first words arriving on SO_chain (last column first),
// tags each with its column index and queues it for the downstream reader.
module tdc_chain_readout #(
  parameter int BITS_UNSIG_TDC = tdc_pkg::BITS_UNSIG_TDC,
  parameter int NUM_COL        = tdc_pkg::NUM_COL,
  parameter int CNT_COL        = tdc_pkg::CNT_COL,
  parameter int PIPE_DLY       = 0
) (
  input  logic                      clk,
  input  logic                      rst_TDC_readout,
  input  logic                      start,
  input  logic                      SO_chain,
  output logic                      flag_col,
  output logic [BITS_UNSIG_TDC-1:0] out_data,
  output logic [CNT_COL-1:0]        out_col,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun,
  output tdc_pkg::tdc_state_e       state_dbg
);

  import tdc_pkg::*;

  localparam int                  BW        = $clog2(BITS_UNSIG_TDC);
  localparam logic [BW-1:0]       BIT_LAST  = BW'(BITS_UNSIG_TDC - 1);
  localparam logic [CNT_COL-1:0]  COL_FIRST = CNT_COL'(NUM_COL - 1);
  localparam logic [1:0]          WAIT_LAST = 2'(PIPE_DLY - 1);

  tdc_state_e                state, state_nxt;
  logic [BW-1:0]             bit_cnt;
  logic [CNT_COL-1:0]        col_cnt;
  logic [1:0]                wait_cnt;
  logic [BITS_UNSIG_TDC-2:0] sr;
  logic [BITS_UNSIG_TDC-1:0] word_in;
  logic                      start_acc;
  logic                      word_push;
  logic                      fifo_drop;

  assign state_dbg = state;
  assign start_acc = (state == ST_IDLE) && start;
  assign word_in   = {sr, SO_chain};
  // The word is complete at the same edge that samples its bit 0.
  assign word_push = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);

  // Next-state decode for the frame sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (PIPE_DLY == 0) ? ST_SHIFT : ST_WAIT;
      ST_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == BIT_LAST && col_cnt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered strobes decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst_TDC_readout) begin
      state      <= ST_IDLE;
      flag_col   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      flag_col   <= (state_nxt == ST_LOAD);
      frame_done <= (state_nxt == ST_DONE);
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Pipeline-wait, bit and column counters and the deserializer.
  always_ff @(posedge clk) begin
    if (rst_TDC_readout) begin
      bit_cnt  <= '0;
      col_cnt  <= '0;
      wait_cnt <= '0;
      sr       <= '0;
    end else begin
      if (start_acc) begin
        bit_cnt  <= '0;
        col_cnt  <= COL_FIRST;
        wait_cnt <= '0;
      end
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (state == ST_SHIFT) begin
        sr <= word_in[BITS_UNSIG_TDC-2:0];
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          col_cnt <= col_cnt - CNT_COL'(1);
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  // Sticky overrun: set by any dropped word, cleared by the next frame.
  always_ff @(posedge clk) begin
    if (rst_TDC_readout)  overrun <= 1'b0;
    else if (start_acc)   overrun <= 1'b0;
    else if (fifo_drop)   overrun <= 1'b1;
  end

  tdc_word_fifo #(
    .W_DATA (BITS_UNSIG_TDC),
    .W_COL  (CNT_COL)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst_TDC_readout),
    .push       (word_push),
    .push_col   (col_cnt),
    .push_data  (word_in),
    .pop_ready  (out_ready),
    .head_data  (out_data),
    .head_col   (out_col),
    .head_valid (out_valid),
    .drop       (fifo_drop)
  );

endmodule

// File: tb/tb_tdc_chain_readout.sv
// Bench for tdc_chain_readout: a behavioural column chain feeds SO_chain,
// one DUT runs with PIPE_DLY=0 and a second with PIPE_DLY=2 behind two
// external register stages.
module tb_tdc_chain_readout;

  localparam int BW = 15;
  localparam int NC = 16;
  localparam int CW = 4;
  localparam int WW = BW + CW;
  localparam int CL = BW * NC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start0 = 1'b0, start2 = 1'b0;
  logic ready0 = 1'b1, ready2 = 1'b1;
  logic so0, so2;

  logic          flag0, valid0, busy0, done0, ovr0;
  logic [BW-1:0] data0;
  logic [CW-1:0] col0;
  tdc_pkg::tdc_state_e st0;
  logic          flag2, valid2, busy2, done2, ovr2;
  logic [BW-1:0] data2;
  logic [CW-1:0] col2;
  tdc_pkg::tdc_state_e st2;

  tdc_chain_readout #(.PIPE_DLY(0)) dut (
    .clk(clk), .rst_TDC_readout(rst), .start(start0), .SO_chain(so0),
    .flag_col(flag0), .out_data(data0), .out_col(col0), .out_valid(valid0),
    .out_ready(ready0), .busy(busy0), .frame_done(done0), .overrun(ovr0),
    .state_dbg(st0)
  );

  tdc_chain_readout #(.PIPE_DLY(2)) dut_p2 (
    .clk(clk), .rst_TDC_readout(rst), .start(start2), .SO_chain(so2),
    .flag_col(flag2), .out_data(data2), .out_col(col2), .out_valid(valid2),
    .out_ready(ready2), .busy(busy2), .frame_done(done2), .overrun(ovr2),
    .state_dbg(st2)
  );

  // ---------------- column chain model ----------------
  logic [BW-1:0] col_words [NC];
  logic [CL-1:0] chain0 = '0, chain2 = '0;
  logic          pipe_d1 = 1'b0, pipe_d2 = 1'b0;

  function automatic logic [CL-1:0] pack_chain();
    logic [CL-1:0] v;
    for (int c = 0; c < NC; c++) v[c*BW +: BW] = col_words[c];
    return v;
  endfunction

  always @(posedge clk) begin
    chain0  <= flag0 ? pack_chain() : {chain0[CL-2:0], 1'b0};
    chain2  <= flag2 ? pack_chain() : {chain2[CL-2:0], 1'b0};
    pipe_d1 <= chain2[CL-1];
    pipe_d2 <= pipe_d1;
  end
  assign so0 = chain0[CL-1];
  assign so2 = pipe_d2;

  // ---------------- scoreboard / observation ----------------
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] exp2_q[$];
  logic [WW-1:0] got0_q[$];
  logic [WW-1:0] got2_q[$];
  logic [WW-1:0] g, e;
  int tests_run = 0, tests_failed = 0;
  int n;
  int flag_cnt0, flag_n0, done_cnt0, done_n0, fv_n0, ov_n0;
  int flag_cnt2, flag_n2, done_cnt2, done_n2, fv_n2;

  task automatic clear_stats();
    flag_cnt0 = 0; flag_n0 = -1; done_cnt0 = 0; done_n0 = -1; fv_n0 = -1; ov_n0 = -1;
    flag_cnt2 = 0; flag_n2 = -1; done_cnt2 = 0; done_n2 = -1; fv_n2 = -1;
    got0_q.delete(); got2_q.delete();
  endtask

  // Advance one cycle: log words popped at the coming edge, then sample
  // the strobes on the falling edge.
  task automatic tick();
    if (valid0 && ready0) got0_q.push_back({col0, data0});
    if (valid2 && ready2) got2_q.push_back({col2, data2});
    @(negedge clk);
    n++;
    if (flag0) begin flag_cnt0++; flag_n0 = n; end
    if (done0) begin done_cnt0++; done_n0 = n; end
    if (valid0 && fv_n0 < 0) fv_n0 = n;
    if (ovr0 && ov_n0 < 0) ov_n0 = n;
    if (flag2) begin flag_cnt2++; flag_n2 = n; end
    if (done2) begin done_cnt2++; done_n2 = n; end
    if (valid2 && fv_n2 < 0) fv_n2 = n;
  endtask

  task automatic set_words();
    col_words[15] = 15'h7FFF;
    col_words[14] = 15'h0000;
    col_words[13] = 15'h5555;
    col_words[12] = 15'h2AAA;
    for (int c = 0; c < 12; c++) col_words[c] = 15'($urandom_range(0, 32767));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; ready0 = 1'b1; ready2 = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (flag0 !== 1'b0) begin tests_failed++; $display("FAIL reset_flag_col got %b exp 0", flag0); end
    tests_run++; if (valid0 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", valid0); end
    tests_run++; if (done0 !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got %b exp 0", done0); end
    tests_run++; if (ovr0 !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b exp 0", ovr0); end
    tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy0); end
    tests_run++; if ({col0, data0} !== '0) begin tests_failed++; $display("FAIL reset_out_word got %h exp 0", {col0, data0}); end
    tests_run++; if (st0 !== tdc_pkg::ST_IDLE) begin tests_failed++; $display("FAIL reset_state got %0d exp 0", st0); end
    tests_run++; if ({busy2, valid2, flag2} !== 3'b000) begin tests_failed++; $display("FAIL reset_p2 got %b exp 000", {busy2, valid2, flag2}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_p0();
    set_words();
    ready0 = 1'b1;
    clear_stats();
    for (int c = NC - 1; c >= 0; c--) exp_q.push_back({CW'(c), col_words[c]});
    start0 = 1'b1; n = -1; tick(); start0 = 1'b0;
    tests_run++; if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL frame_busy_start got %b exp 1", busy0); end
    tests_run++; if (ovr0 !== 1'b0) begin tests_failed++; $display("FAIL frame_overrun_clear got %b exp 0", ovr0); end
    for (int k = 0; k < 250; k++) begin
      tick();
      if (n == 120) begin
        tests_run++; if (st0 !== tdc_pkg::ST_SHIFT) begin tests_failed++; $display("FAIL frame_mid_state got %0d exp 3", st0); end
      end
    end
    tests_run++; if (flag_cnt0 != 1 || flag_n0 != 0) begin tests_failed++; $display("FAIL frame_flag_col got cnt=%0d at=%0d exp cnt=1 at=0", flag_cnt0, flag_n0); end
    tests_run++; if (fv_n0 != 16) begin tests_failed++; $display("FAIL frame_first_valid got %0d exp 16", fv_n0); end
    tests_run++; if (done_cnt0 != 1 || done_n0 != 241) begin tests_failed++; $display("FAIL frame_done got cnt=%0d at=%0d exp cnt=1 at=241", done_cnt0, done_n0); end
    tests_run++; if (got0_q.size() != NC) begin tests_failed++; $display("FAIL frame_word_count got %0d exp %0d", got0_q.size(), NC); end
    while (got0_q.size() > 0 && exp_q.size() > 0) begin
      g = got0_q.pop_front(); e = exp_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL frame_word got col=%0d data=%h exp col=%0d data=%h", g[WW-1:BW], g[BW-1:0], e[WW-1:BW], e[BW-1:0]); end
    end
    tests_run++; if (busy0 !== 1'b0 || st0 !== tdc_pkg::ST_IDLE) begin tests_failed++; $display("FAIL frame_end_idle got busy=%b state=%0d exp busy=0 state=0", busy0, st0); end
    exp_q.delete();
  endtask

  task automatic test_pipe_dly();
    ready2 = 1'b1;
    clear_stats();
    for (int c = NC - 1; c >= 0; c--) exp2_q.push_back({CW'(c), col_words[c]});
    start2 = 1'b1; n = -1; tick(); start2 = 1'b0;
    repeat (255) tick();
    tests_run++; if (flag_cnt2 != 1 || flag_n2 != 0) begin tests_failed++; $display("FAIL p2_flag_col got cnt=%0d at=%0d exp cnt=1 at=0", flag_cnt2, flag_n2); end
    tests_run++; if (fv_n2 != 18) begin tests_failed++; $display("FAIL p2_first_valid got %0d exp 18", fv_n2); end
    tests_run++; if (done_cnt2 != 1 || done_n2 != 243) begin tests_failed++; $display("FAIL p2_frame_done got cnt=%0d at=%0d exp cnt=1 at=243", done_cnt2, done_n2); end
    tests_run++; if (got2_q.size() != NC) begin tests_failed++; $display("FAIL p2_word_count got %0d exp %0d", got2_q.size(), NC); end
    while (got2_q.size() > 0 && exp2_q.size() > 0) begin
      g = got2_q.pop_front(); e = exp2_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL p2_word got %h exp %h", g, e); end
    end
    exp2_q.delete();
  endtask

  task automatic test_backpressure();
    set_words();
    clear_stats();
    exp_q.push_back({CW'(15), col_words[15]});
    exp_q.push_back({CW'(14), col_words[14]});
    ready0 = 1'b0;
    start0 = 1'b1; n = -1; tick(); start0 = 1'b0;
    repeat (250) tick();
    tests_run++; if (got0_q.size() != 0) begin tests_failed++; $display("FAIL bp_no_pop got %0d exp 0", got0_q.size()); end
    tests_run++; if (ov_n0 != 46) begin tests_failed++; $display("FAIL bp_overrun_at got %0d exp 46", ov_n0); end
    tests_run++; if (ovr0 !== 1'b1 || valid0 !== 1'b1) begin tests_failed++; $display("FAIL bp_hold got overrun=%b valid=%b exp 1 1", ovr0, valid0); end
    tests_run++; if (done_n0 != 241) begin tests_failed++; $display("FAIL bp_frame_done got %0d exp 241", done_n0); end
    ready0 = 1'b1;
    repeat (4) tick();
    tests_run++; if (got0_q.size() != 2) begin tests_failed++; $display("FAIL bp_retained got %0d exp 2", got0_q.size()); end
    while (got0_q.size() > 0 && exp_q.size() > 0) begin
      g = got0_q.pop_front(); e = exp_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL bp_word got %h exp %h", g, e); end
    end
    tests_run++; if (ovr0 !== 1'b1 || valid0 !== 1'b0) begin tests_failed++; $display("FAIL bp_drained got overrun=%b valid=%b exp 1 0", ovr0, valid0); end
    exp_q.delete();
    test_frame_p0();
  endtask

  task automatic test_start_in_shift();
    set_words();
    ready0 = 1'b1;
    clear_stats();
    for (int c = NC - 1; c >= 0; c--) exp_q.push_back({CW'(c), col_words[c]});
    start0 = 1'b1; n = -1; tick(); start0 = 1'b0;
    for (int k = 0; k < 250; k++) begin
      start0 = (n == 100);
      tick();
    end
    start0 = 1'b0;
    tests_run++; if (flag_cnt0 != 1) begin tests_failed++; $display("FAIL shift_start_flag got %0d exp 1", flag_cnt0); end
    tests_run++; if (done_cnt0 != 1 || got0_q.size() != NC) begin tests_failed++; $display("FAIL shift_start_count got done=%0d words=%0d exp 1 %0d", done_cnt0, got0_q.size(), NC); end
    while (got0_q.size() > 0 && exp_q.size() > 0) begin
      g = got0_q.pop_front(); e = exp_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL shift_start_word got %h exp %h", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_shift();
    set_words();
    ready0 = 1'b1;
    clear_stats();
    for (int c = NC - 1; c >= 0; c--)
      if (1 + BW * (NC - c) < 101) exp_q.push_back({CW'(c), col_words[c]});
    start0 = 1'b1; n = -1; tick(); start0 = 1'b0;
    while (n < 100) tick();
    rst = 1'b1;
    tick();
    tests_run++; if ({flag0, valid0, done0, ovr0, busy0} !== 5'b0) begin tests_failed++; $display("FAIL midrst_flags got %b exp 00000", {flag0, valid0, done0, ovr0, busy0}); end
    tests_run++; if ({col0, data0} !== '0) begin tests_failed++; $display("FAIL midrst_word got %h exp 0", {col0, data0}); end
    tests_run++; if (st0 !== tdc_pkg::ST_IDLE) begin tests_failed++; $display("FAIL midrst_state got %0d exp 0", st0); end
    rst = 1'b0;
    repeat (3) tick();
    tests_run++; if (got0_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL midrst_count got %0d exp %0d", got0_q.size(), exp_q.size()); end
    while (got0_q.size() > 0 && exp_q.size() > 0) begin
      g = got0_q.pop_front(); e = exp_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL midrst_word got %h exp %h", g, e); end
    end
    exp_q.delete();
    test_frame_p0();
  endtask

  task automatic test_back_to_back();
    set_words();
    clear_stats();
    for (int c = NC - 1; c >= 0; c--) exp_q.push_back({CW'(c), col_words[c]});
    ready0 = 1'b0;
    start0 = 1'b1; n = -1; tick(); start0 = 1'b0;
    for (int k = 0; k < 250; k++) begin
      ready0 = (n >= 45) && (n != 46);
      tick();
      if (n == 47) begin
        tests_run++; if (valid0 !== 1'b1 || ovr0 !== 1'b0) begin tests_failed++; $display("FAIL b2b_mid got valid=%b overrun=%b exp 1 0", valid0, ovr0); end
      end
    end
    ready0 = 1'b1;
    tests_run++; if (ov_n0 != -1) begin tests_failed++; $display("FAIL b2b_overrun got at=%0d exp never", ov_n0); end
    tests_run++; if (got0_q.size() != NC) begin tests_failed++; $display("FAIL b2b_count got %0d exp %0d", got0_q.size(), NC); end
    while (got0_q.size() > 0 && exp_q.size() > 0) begin
      g = got0_q.pop_front(); e = exp_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL b2b_word got %h exp %h", g, e); end
    end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_words();
    clear_stats();
    n = 0;
    test_reset();
    test_frame_p0();
    test_pipe_dly();
    test_backpressure();
    test_start_in_shift();
    test_reset_mid_shift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tdc_chain_readout.md
# tdc_chain_readout

Chain-end controller and deserializer for the TDC column daisy chain. On a frame request it issues the one-cycle `flag_col` load pulse to every column TDC interface, then receives the 15-bit unsigned words that the columns shift out MSB-first through the chain's final `SO`. It reassembles each word, tags it with its column index and hands it to the downstream readout over a valid/ready port, buffering it in a 2-entry FIFO. It sits between the column TDC interfaces and the SPI/readout logic.

## Interface
- `BITS_UNSIG_TDC`, 15: word width per column.
- `NUM_COL`, 16: number of columns in the chain.
- `CNT_COL`, 4: column index width; must satisfy 2^CNT_COL ≥ NUM_COL.
- `PIPE_DLY`, 0: number of register stages (0–3) between the last column's `SO` and `SO_chain`.

Ports:
- `clk` in 1: single system clock, shared with the column TDC interfaces.
- `rst_TDC_readout` in 1: reset. Synchronous, active-high.
- `start` in 1: frame request. Accepted only in IDLE.
- `SO_chain` in 1: serial output of the last column in the chain.
- `flag_col` out 1: load pulse to all column interfaces. Registered.
- `out_data` out BITS_UNSIG_TDC: recovered word.
- `out_col` out CNT_COL: column index of `out_data`.
- `out_valid` out 1: `out_data`/`out_col` are valid.
- `out_ready` in 1: downstream accepts the word.
- `busy` out 1: a frame is in progress (not IDLE).
- `frame_done` out 1: one-cycle pulse at the end of the frame.
- `overrun` out 1: sticky flag; a word was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, LOAD, WAIT, SHIFT, DONE.
  - IDLE → LOAD on `start`.
  - LOAD lasts 1 cycle; `flag_col`=1 only in this state.
  - WAIT lasts PIPE_DLY cycles (skipped when PIPE_DLY=0).
  - SHIFT lasts exactly BITS_UNSIG_TDC×NUM_COL cycles.
  - DONE lasts 1 cycle with `frame_done`=1, then returns to IDLE.
- Shifting:
  - Each SHIFT cycle samples `SO_chain` into a shift register: `sr <= {sr[13:0], SO_chain}`.
  - Bit counter runs 0..14 and wraps to 0.
  - Column counter starts at NUM_COL-1 and decrements each time the bit counter wraps.
- Word order: the first word is column NUM_COL-1 and the last is column 0. The word is pushed at the same edge that samples its bit 0.
- FIFO: 2 entries of {col, data}. A push when full drops the word and sets `overrun`. A simultaneous push and pop on a full FIFO is legal and does not overrun.
- `overrun` clears when `start` is accepted.
- Shifting never stalls, because the chain shifts every clock.
- `start` outside IDLE is ignored.
- `busy` is high in LOAD, WAIT, SHIFT and DONE. The FIFO may still hold words after DONE.
- A new `start` is legal in the cycle after DONE. The column interfaces clear their BUF1 two cycles after `flag_col`; this is independent of this block.
- Reset (any state):
  - FSM returns to IDLE and the counters clear.
  - FIFO is flushed.
  - `flag_col`, `out_valid`, `frame_done`, `overrun`, `busy` = 0; `out_data` = 0; `out_col` = 0.

## Timing
- `start` sampled high at edge E0 → `flag_col` high for the cycle after E0. The columns load BUF2 at the next edge, E1.
- With PIPE_DLY=0:
  - `SO_chain` carries bit 14 of column NUM_COL-1 in the cycle after E1, sampled at E2.
  - That column's bit 0 is sampled at E16.
  - `out_valid` rises after E16 (push-to-valid latency 1 cycle, registered FIFO output).
  - Column 0's bit 0 is sampled at edge E1+15×NUM_COL (E241 for 16 columns).
  - DONE occupies the following cycle; `frame_done` is high after E241.
- Each extra PIPE_DLY stage shifts every event after E1 by one cycle.
- A pop happens at an edge where `out_valid && out_ready`.

## Structure
- Shared package `tdc_pkg` holds BITS_UNSIG_TDC, NUM_COL, CNT_COL and the FSM state encoding (4-bit, shared style with the command FSM).
- One sub-module, `tdc_word_fifo`: 2-entry synchronous FIFO with a registered output, full/empty flags and a push-when-full drop indication.

## Test plan
- Load columns 15..0 with words 0x7FFF, 0x0000, 0x5555, 0x2AAA, …; pulse `start` with `out_ready`=1 → 16 words emitted, `out_col` 15 down to 0, data bit-exact. First `out_valid` 16 cycles after `flag_col`. `frame_done` 241 cycles after `flag_col`.
- Same frame with PIPE_DLY=2 → every event after `flag_col` is delayed by 2 cycles; data identical.
- Hold `out_ready`=0 for the whole frame → first 2 words (cols 15, 14) retained, `overrun`=1 from col 13 onward. Next `start` clears `overrun`.
- Assert `start` during SHIFT → ignored: no second `flag_col`, word count stays 16.
- Assert `rst_TDC_readout` at SHIFT cycle 100 → next cycle all outputs are 0 and the FSM is IDLE. A fresh `start` yields a correct full frame.
- Drop `out_ready` for exactly 1 cycle while the FIFO holds 2 words and a push lands → simultaneous push/pop, no `overrun`, order preserved.
